// File: rtl/perf_event_counter.sv
// Multi-channel pipeline event counter with a bounded run window, atomic
// snapshot into shadow registers and a registered indexed readout.
module perf_event_counter #(
    parameter int NUM_CH     = 4,
    parameter int CNT_W      = 32,
    parameter int MAX_CYCLES = 64,
    parameter int SATURATE   = 1,
    parameter int SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              clear_i,
    input  logic [NUM_CH-1:0] event_i,
    input  logic              snap_i,
    input  logic [SEL_W-1:0]  rd_sel_i,
    output logic [CNT_W-1:0]  rd_data_o,
    output logic [CNT_W-1:0]  cycle_o,
    output logic [CNT_W-1:0]  snap_cycle_o,
    output logic [NUM_CH-1:0] ovf_o,
    output logic              running_o,
    output logic              done_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] ALL_ONES = '1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt    [NUM_CH];
    logic [CNT_W-1:0] shadow [NUM_CH];
    logic [CNT_W-1:0] cycle_nxt;
    logic [CNT_W-1:0] rd_mux;
    logic             count_en;
    logic             hit_max;

    // Increment with the configured overflow policy.
    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
        if (v == ALL_ONES) begin
            return (SATURATE != 0) ? v : '0;
        end
        return v + CNT_W'(1);
    endfunction

    assign count_en  = (state_q == S_RUN) && start_i;
    assign cycle_nxt = bump(cycle_o);
    // A window longer than the counter can represent simply never closes.
    assign hit_max   = (MAX_CYCLES != 0) && (64'(cycle_nxt) == 64'(MAX_CYCLES));

    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (start_i) state_d = S_RUN;
                S_RUN:   if (count_en && hit_max) state_d = S_DONE;
                S_DONE:  state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign running_o = (state_q == S_RUN);
    assign done_o    = (state_q == S_DONE);

    // Out-of-range selects fall through to zero.
    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (rd_sel_i == SEL_W'(k)) rd_mux = shadow[k];
        end
    end

    // NOTE: the shadow array is architecturally visible through rd_data_o, so it
    // is reset like any other register rather than left as unreset storage.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int k = 0; k < NUM_CH; k++) begin
                cnt[k]    <= '0;
                shadow[k] <= '0;
            end
            cycle_o      <= '0;
            snap_cycle_o <= '0;
            rd_data_o    <= '0;
            ovf_o        <= '0;
        end else if (clear_i) begin
            for (int k = 0; k < NUM_CH; k++) begin
                cnt[k]    <= '0;
                shadow[k] <= '0;
            end
            cycle_o      <= '0;
            snap_cycle_o <= '0;
            rd_data_o    <= '0;
            ovf_o        <= '0;
        end else begin
            // Snapshot takes the pre-increment values of this edge.
            if (snap_i) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    shadow[k] <= cnt[k];
                end
                snap_cycle_o <= cycle_o;
            end
            if (count_en) begin
                cycle_o <= cycle_nxt;
                for (int k = 0; k < NUM_CH; k++) begin
                    if (event_i[k]) begin
                        cnt[k] <= bump(cnt[k]);
                        if (cnt[k] == ALL_ONES) ovf_o[k] <= 1'b1;
                    end
                end
            end
            rd_data_o <= rd_mux;
        end
    end

endmodule

// File: tb/tb_perf_event_counter.sv
// Directed bench: a default-parameter instance for window/snapshot/pause/clear
// behaviour, plus 4-bit saturating and wrapping instances for overflow.
module tb_perf_event_counter;

    logic clk;
    logic rst;

    logic        m_start, m_clear, m_snap;
    logic [3:0]  m_event;
    logic [1:0]  m_sel;
    logic [31:0] m_rd, m_cycle, m_snapc;
    logic [3:0]  m_ovf;
    logic        m_run, m_done;

    logic        s_start, s_clear, s_snap;
    logic [2:0]  s_event;
    logic [1:0]  s_sel;
    logic [3:0]  a_rd, a_cycle, a_snapc, w_rd, w_cycle, w_snapc;
    logic [2:0]  a_ovf, w_ovf;
    logic        a_run, a_done, w_run, w_done;

    int checks   = 0;
    int failures = 0;

    perf_event_counter #(.NUM_CH(4), .CNT_W(32), .MAX_CYCLES(64), .SATURATE(1)) u_main (
        .clk_i(clk), .rst_i(rst), .start_i(m_start), .clear_i(m_clear), .event_i(m_event),
        .snap_i(m_snap), .rd_sel_i(m_sel), .rd_data_o(m_rd), .cycle_o(m_cycle),
        .snap_cycle_o(m_snapc), .ovf_o(m_ovf), .running_o(m_run), .done_o(m_done));

    perf_event_counter #(.NUM_CH(3), .CNT_W(4), .MAX_CYCLES(0), .SATURATE(1)) u_sat (
        .clk_i(clk), .rst_i(rst), .start_i(s_start), .clear_i(s_clear), .event_i(s_event),
        .snap_i(s_snap), .rd_sel_i(s_sel), .rd_data_o(a_rd), .cycle_o(a_cycle),
        .snap_cycle_o(a_snapc), .ovf_o(a_ovf), .running_o(a_run), .done_o(a_done));

    perf_event_counter #(.NUM_CH(3), .CNT_W(4), .MAX_CYCLES(0), .SATURATE(0)) u_wrap (
        .clk_i(clk), .rst_i(rst), .start_i(s_start), .clear_i(s_clear), .event_i(s_event),
        .snap_i(s_snap), .rd_sel_i(s_sel), .rd_data_o(w_rd), .cycle_o(w_cycle),
        .snap_cycle_o(w_snapc), .ovf_o(w_ovf), .running_o(w_run), .done_o(w_done));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        snap;
        logic [3:0]  ev;
        logic [1:0]  sel;
        logic [31:0] exp_cycle;
        logic [31:0] exp_rd;
        logic [31:0] exp_snapc;
        logic        exp_run;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs [6];

    initial begin
        vecs[0] = '{1'b1, 1'b0, 4'b0101, 2'd0, 32'd0, 32'd0, 32'd0, 1'b1};
        vecs[1] = '{1'b1, 1'b0, 4'b0101, 2'd0, 32'd1, 32'd0, 32'd0, 1'b1};
        vecs[2] = '{1'b1, 1'b1, 4'b0101, 2'd0, 32'd2, 32'd0, 32'd1, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 4'b0101, 2'd0, 32'd3, 32'd1, 32'd1, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 4'b0101, 2'd1, 32'd4, 32'd0, 32'd1, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 4'b0101, 2'd2, 32'd5, 32'd1, 32'd1, 1'b1};

        rst = 1'b0;
        m_start = 0; m_clear = 0; m_snap = 0; m_event = '0; m_sel = '0;
        s_start = 0; s_clear = 0; s_snap = 0; s_event = '0; s_sel = '0;
        tick();
        tick();
        check("rst_cycle", m_cycle, 0);
        check("rst_rd", m_rd, 0);
        check("rst_snapc", m_snapc, 0);
        check("rst_ovf", m_ovf, 0);
        check("rst_running", m_run, 0);
        check("rst_done", m_done, 0);
        rst = 1'b1;
        tick();
        check("idle_running", m_run, 0);

        // Full window: start edge, then 64 counted edges with event 0101.
        for (int i = 0; i < 6; i++) begin
            m_start = vecs[i].start; m_snap = vecs[i].snap;
            m_event = vecs[i].ev;    m_sel  = vecs[i].sel;
            tick();
            check($sformatf("vec%0d_cycle", i), m_cycle, vecs[i].exp_cycle);
            check($sformatf("vec%0d_rd", i), m_rd, vecs[i].exp_rd);
            check($sformatf("vec%0d_snapc", i), m_snapc, vecs[i].exp_snapc);
            check($sformatf("vec%0d_running", i), m_run, vecs[i].exp_run);
        end
        m_snap = 0;
        for (int i = 0; i < 59; i++) begin
            tick();
            if (i == 57) begin
                check("win_cycle63", m_cycle, 63);
                check("win_done_early", m_done, 0);
            end
        end
        check("win_cycle64", m_cycle, 64);
        check("win_done", m_done, 1);
        check("win_running", m_run, 0);

        m_event = 4'b1111;
        for (int i = 0; i < 5; i++) tick();
        check("done_frozen_cycle", m_cycle, 64);
        check("done_stays", m_done, 1);
        m_snap = 1;
        tick();
        m_snap = 0;
        check("done_snapc", m_snapc, 64);
        for (int k = 0; k < 4; k++) begin
            m_sel = 2'(k);
            tick();
            check($sformatf("done_rd%0d", k), m_rd, (k % 2 == 0) ? 64 : 0);
        end
        check("done_ovf", m_ovf, 0);

        // Clear with start and snap also asserted.
        m_sel = 2'd0; m_clear = 1; m_start = 1; m_snap = 1; m_event = 4'b1111;
        tick();
        m_clear = 0; m_snap = 0; m_start = 0; m_event = '0;
        check("clr_cycle", m_cycle, 0);
        check("clr_running", m_run, 0);
        check("clr_done", m_done, 0);
        check("clr_snapc", m_snapc, 0);
        tick();
        check("clr_idle", m_run, 0);
        check("clr_rd0", m_rd, 0);

        // Snapshot coinciding with an event on channel 1 at count 7.
        m_start = 1;
        tick();
        m_event = 4'b0010;
        for (int i = 0; i < 7; i++) tick();
        check("pre_snap_cycle", m_cycle, 7);
        m_snap = 1;
        tick();
        m_snap = 0; m_event = '0; m_sel = 2'd1;
        check("snap_cycle_cap", m_snapc, 7);
        check("snap_live_cycle", m_cycle, 8);
        tick();
        check("snap_rd1", m_rd, 7);

        // Pause with toggling events.
        m_start = 0;
        for (int i = 0; i < 10; i++) begin
            m_event = (i % 2 == 0) ? 4'b1111 : 4'b0000;
            tick();
            check($sformatf("pause%0d_cycle", i), m_cycle, 9);
            check($sformatf("pause%0d_running", i), m_run, 1);
        end
        m_event = '0; m_snap = 1;
        tick();
        m_snap = 0;
        check("pause_snapc", m_snapc, 9);
        tick();
        check("pause_rd1_live", m_rd, 8);
        m_sel = 2'd0;
        tick();
        check("pause_rd0_live", m_rd, 0);

        m_start = 1; m_event = 4'b0001;
        for (int i = 0; i < 21; i++) tick();
        check("resume_cycle30", m_cycle, 30);
        check("resume_running", m_run, 1);

        m_clear = 1; m_snap = 1; m_event = 4'b1111;
        tick();
        m_clear = 0; m_snap = 0; m_start = 0; m_event = '0;
        check("clr30_cycle", m_cycle, 0);
        check("clr30_snapc", m_snapc, 0);
        check("clr30_ovf", m_ovf, 0);
        check("clr30_running", m_run, 0);
        for (int k = 0; k < 4; k++) begin
            m_sel = 2'(k);
            tick();
            check($sformatf("clr30_rd%0d", k), m_rd, 0);
        end
        check("clr30_idle", m_run, 0);

        // Asynchronous reset between edges.
        m_start = 1;
        tick();
        m_event = 4'b0001;
        for (int i = 0; i < 5; i++) tick();
        m_snap = 1;
        tick();
        m_snap = 0; m_sel = 2'd0;
        tick();
        check("prerst_rd", m_rd, 5);
        check("prerst_snapc", m_snapc, 5);
        #2;
        rst = 1'b0;
        #1;
        check("arst_cycle", m_cycle, 0);
        check("arst_rd", m_rd, 0);
        check("arst_snapc", m_snapc, 0);
        check("arst_running", m_run, 0);
        m_start = 0; m_event = '0;
        tick();
        rst = 1'b1;
        tick();

        // Overflow: 4-bit counters, saturate vs wrap, unbounded window.
        s_start = 1;
        tick();
        s_event = 3'b001;
        for (int i = 0; i < 15; i++) tick();
        check("sat_pre_ovf", a_ovf, 0);
        check("wrap_pre_ovf", w_ovf, 0);
        check("wrap_cycle15", w_cycle, 15);
        tick();
        check("sat_ovf", a_ovf, 3'b001);
        check("wrap_ovf", w_ovf, 3'b001);
        check("sat_cycle_hold", a_cycle, 15);
        check("wrap_cycle_wrap", w_cycle, 0);
        for (int i = 0; i < 4; i++) tick();
        check("wrap_cycle20", w_cycle, 4);
        s_start = 0; s_event = '0; s_snap = 1;
        tick();
        s_snap = 0; s_sel = 2'd0;
        tick();
        check("sat_rd0", a_rd, 15);
        check("wrap_rd0", w_rd, 4);
        check("sat_unbounded", a_done, 0);
        check("wrap_unbounded", w_done, 0);
        s_sel = 2'd3;
        tick();
        check("sat_rd_oob", a_rd, 0);
        check("wrap_rd_oob", w_rd, 0);
        check("sat_ovf_sticky", a_ovf, 3'b001);
        s_clear = 1;
        tick();
        s_clear = 0;
        check("sat_ovf_clr", a_ovf, 0);
        check("wrap_ovf_clr", w_ovf, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
